// File: rtl/bp_layered_decoder_controller_if.sv
// Control/status bundle between the layered BP controller and its neighbours
// (decoder wrapper handshake plus datapath strobes and status).
interface bp_layered_decoder_controller_if #(
    parameter int unsigned ITER_W  = 4,
    parameter int unsigned LAYER_W = 5
);
    // wrapper / datapath -> controller
    logic               start;
    logic               abort;
    logic               done_row_processing;
    logic               syndrome_ok;
    // controller -> datapath strobes
    logic               start_row_processing;
    logic               initialize_storage_matrix;
    logic               load_storage_matrix;
    logic               load_sum_vector;
    logic               select_input_to_storage_matrix;
    logic               reset_main_counter;
    logic               increment_main_counter;
    logic               reset_layer_indicator_counter;
    logic               increment_layer_indicator_counter;
    logic               reset_layer_counter;
    // controller -> wrapper status
    logic               busy;
    logic               done;
    logic               converged;
    logic               timeout_error;
    logic [ITER_W-1:0]  iterations_used;
    logic [LAYER_W-1:0] current_layer;

    // controller side
    modport master (
        input  start, abort, done_row_processing, syndrome_ok,
        output start_row_processing, initialize_storage_matrix, load_storage_matrix,
               load_sum_vector, select_input_to_storage_matrix, reset_main_counter,
               increment_main_counter, reset_layer_indicator_counter,
               increment_layer_indicator_counter, reset_layer_counter,
               busy, done, converged, timeout_error, iterations_used, current_layer
    );

    // wrapper / datapath side
    modport slave (
        output start, abort, done_row_processing, syndrome_ok,
        input  start_row_processing, initialize_storage_matrix, load_storage_matrix,
               load_sum_vector, select_input_to_storage_matrix, reset_main_counter,
               increment_main_counter, reset_layer_indicator_counter,
               increment_layer_indicator_counter, reset_layer_counter,
               busy, done, converged, timeout_error, iterations_used, current_layer
    );
endinterface

// File: rtl/bp_layered_decoder_controller.sv
// Sequencer for the layered belief-propagation LDPC datapath: walks every
// layer of each iteration, then iterations until the cap, early termination,
// a row-processing timeout or an abort. Outputs are registered and change on
// the same edge as the state they belong to.
module bp_layered_decoder_controller #(
    parameter int unsigned NUM_LAYERS     = 16,
    parameter int unsigned MAX_ITERATIONS = 10,
    parameter int unsigned ITER_W         = 4,
    parameter int unsigned LAYER_W        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          EARLY_TERM_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    bp_layered_decoder_controller_if.master ctrl
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ROW_START, S_ROW_WAIT, S_ROW_WRITE, S_ITER_END, S_DONE
    } state_e;

    state_e              state_q;
    logic [LAYER_W-1:0]  layer_q;
    logic [ITER_W-1:0]   iter_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                srp_q, ism_q, lsm_q, lsv_q, sel_q;
    logic                rmc_q, imc_q, rlic_q, ilic_q, rlc_q;
    logic                busy_q, done_q, conv_q, tout_q;
    logic [ITER_W-1:0]   iters_used_q;
    logic                abort_c;

    // abort is honoured in every busy state except the final DONE cycle
    assign abort_c = ctrl.abort && (state_q != S_IDLE) && (state_q != S_DONE);

    // state, counters and registered outputs; strobes default low each cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            layer_q      <= '0;
            iter_q       <= '0;
            wait_q       <= '0;
            srp_q        <= 1'b0;
            ism_q        <= 1'b0;
            lsm_q        <= 1'b0;
            lsv_q        <= 1'b0;
            sel_q        <= 1'b0;
            rmc_q        <= 1'b0;
            imc_q        <= 1'b0;
            rlic_q       <= 1'b0;
            ilic_q       <= 1'b0;
            rlc_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            conv_q       <= 1'b0;
            tout_q       <= 1'b0;
            iters_used_q <= '0;
        end else begin
            srp_q  <= 1'b0;
            ism_q  <= 1'b0;
            lsm_q  <= 1'b0;
            lsv_q  <= 1'b0;
            sel_q  <= 1'b0;
            rmc_q  <= 1'b0;
            imc_q  <= 1'b0;
            rlic_q <= 1'b0;
            ilic_q <= 1'b0;
            rlc_q  <= 1'b0;
            done_q <= 1'b0;
            if (abort_c) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                conv_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ctrl.start) begin
                            state_q      <= S_INIT;
                            ism_q        <= 1'b1;
                            rmc_q        <= 1'b1;
                            rlic_q       <= 1'b1;
                            rlc_q        <= 1'b1;
                            busy_q       <= 1'b1;
                            conv_q       <= 1'b0;
                            tout_q       <= 1'b0;
                            iters_used_q <= '0;
                            layer_q      <= '0;
                            iter_q       <= '0;
                        end
                    end
                    S_INIT: begin
                        state_q <= S_ROW_START;
                        srp_q   <= 1'b1;
                        wait_q  <= '0;
                    end
                    S_ROW_START: begin
                        state_q <= S_ROW_WAIT;
                    end
                    S_ROW_WAIT: begin
                        if (ctrl.done_row_processing) begin
                            state_q <= S_ROW_WRITE;
                            lsm_q   <= 1'b1;
                            lsv_q   <= 1'b1;
                            sel_q   <= 1'b1;
                            ilic_q  <= 1'b1;
                        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            tout_q  <= 1'b1;
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end
                    S_ROW_WRITE: begin
                        if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
                            state_q      <= S_ITER_END;
                            layer_q      <= '0;
                            imc_q        <= 1'b1;
                            rlic_q       <= 1'b1;
                            iters_used_q <= iter_q + ITER_W'(1);
                        end else begin
                            state_q <= S_ROW_START;
                            layer_q <= layer_q + LAYER_W'(1);
                            srp_q   <= 1'b1;
                            wait_q  <= '0;
                        end
                    end
                    S_ITER_END: begin
                        if (EARLY_TERM_EN && ctrl.syndrome_ok) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            conv_q  <= 1'b1;
                        end else if (iter_q == ITER_W'(MAX_ITERATIONS - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            conv_q  <= 1'b0;
                        end else begin
                            state_q <= S_ROW_START;
                            iter_q  <= iter_q + ITER_W'(1);
                            srp_q   <= 1'b1;
                            wait_q  <= '0;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl.start_row_processing              = srp_q;
    assign ctrl.initialize_storage_matrix         = ism_q;
    assign ctrl.load_storage_matrix               = lsm_q;
    assign ctrl.load_sum_vector                   = lsv_q;
    assign ctrl.select_input_to_storage_matrix    = sel_q;
    assign ctrl.reset_main_counter                = rmc_q;
    assign ctrl.increment_main_counter            = imc_q;
    assign ctrl.reset_layer_indicator_counter     = rlic_q;
    assign ctrl.increment_layer_indicator_counter = ilic_q;
    assign ctrl.reset_layer_counter               = rlc_q;
    assign ctrl.busy                              = busy_q;
    assign ctrl.done                              = done_q;
    assign ctrl.converged                         = conv_q;
    assign ctrl.timeout_error                     = tout_q;
    assign ctrl.iterations_used                   = iters_used_q;
    assign ctrl.current_layer                     = layer_q;

endmodule

// File: tb/tb_bp_layered_decoder_controller.sv
// Scoreboard bench for the layered BP controller: stimulus pushes the expected
// end-of-decode record, a monitor pops and compares it on every done pulse.
module tb_bp_layered_decoder_controller;

    localparam int unsigned NL = 16;
    localparam int unsigned MI = 10;
    localparam int unsigned IW = 4;
    localparam int unsigned LW = 5;
    localparam int unsigned TO = 8;

    typedef struct {
        int cyc;
        int conv;
        int tout;
        int iters;
        int srp;
        int lsm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    bit   dp_en = 1'b1;
    bit   synd_en = 1'b0;
    int   launch_cyc = 0;

    bp_layered_decoder_controller_if #(.ITER_W(IW), .LAYER_W(LW)) ifc ();

    bp_layered_decoder_controller #(
        .NUM_LAYERS(NL), .MAX_ITERATIONS(MI), .ITER_W(IW), .LAYER_W(LW),
        .TIMEOUT_CYCLES(TO), .EARLY_TERM_EN(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ctrl(ifc.master)
    );

    always #5 clk = ~clk;

    logic [22:0] all_outs;
    assign all_outs = {ifc.start_row_processing, ifc.initialize_storage_matrix,
                       ifc.load_storage_matrix, ifc.load_sum_vector,
                       ifc.select_input_to_storage_matrix, ifc.reset_main_counter,
                       ifc.increment_main_counter, ifc.reset_layer_indicator_counter,
                       ifc.increment_layer_indicator_counter, ifc.reset_layer_counter,
                       ifc.busy, ifc.done, ifc.converged, ifc.timeout_error,
                       ifc.iterations_used, ifc.current_layer};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // free-running posedge count, used to time done pulses
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // datapath model: done_row_processing one cycle after start_row_processing,
    // syndrome_ok raised only while iterations_used reads 3
    initial begin
        logic srp_seen;
        ifc.done_row_processing = 1'b0;
        ifc.syndrome_ok = 1'b0;
        forever begin
            @(negedge clk);
            srp_seen = ifc.start_row_processing;
            @(posedge clk);
            #1;
            ifc.done_row_processing = dp_en && srp_seen;
            ifc.syndrome_ok = synd_en && (ifc.iterations_used == IW'(3));
        end
    end

    // monitor: counts strobes per decode and checks each done against the scoreboard
    initial begin
        int srp_cnt = 0;
        int lsm_cnt = 0;
        int init_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                srp_cnt = 0;
                lsm_cnt = 0;
                init_cnt = 0;
            end else begin
                if (ifc.initialize_storage_matrix) begin
                    srp_cnt = 0;
                    lsm_cnt = 0;
                    init_cnt++;
                end
                if (ifc.start_row_processing) srp_cnt++;
                if (ifc.load_storage_matrix) lsm_cnt++;
                if (ifc.done) begin
                    check("sb_has_entry", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("done_cycle", cyc - e.cyc, 0);
                        check("converged", int'(ifc.converged), e.conv);
                        check("timeout_error", int'(ifc.timeout_error), e.tout);
                        check("iterations_used", int'(ifc.iterations_used), e.iters);
                        check("row_start_pulses", srp_cnt, e.srp);
                        check("storage_loads", lsm_cnt, e.lsm);
                        check("init_pulses", init_cnt, 1);
                        check("busy_in_done", int'(ifc.busy), 1);
                    end
                    init_cnt = 0;
                end
            end
        end
    end

    task automatic push_exp(input int dcyc, input int conv, input int tout,
                            input int iters, input int srp, input int lsm);
        exp_t e;
        e.cyc = dcyc; e.conv = conv; e.tout = tout;
        e.iters = iters; e.srp = srp; e.lsm = lsm;
        sb_q.push_back(e);
    endtask

    // one-cycle start pulse; launch_cyc is the edge count at which start is driven
    task automatic launch();
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        launch_cyc = cyc;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.done && n < budget);
        check("done_seen", int'(ifc.done), 1);
    endtask

    initial begin
        int n;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(all_outs), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // full run to the iteration cap: 1 + 10*49 cycles after the sampling edge
        launch();
        push_exp(launch_cyc + 492, 0, 0, 10, 160, 160);
        wait_done(600);
        @(negedge clk);
        check("idle_after_run", int'(ifc.busy), 0);

        // early termination at the third ITER_END
        synd_en = 1'b1;
        launch();
        push_exp(launch_cyc + 149, 1, 0, 3, 48, 48);
        wait_done(300);
        synd_en = 1'b0;
        @(negedge clk);

        // row processing never returns: timeout 8 cycles after ROW_WAIT entry
        dp_en = 1'b0;
        launch();
        push_exp(launch_cyc + 11, 0, 1, 0, 1, 0);
        wait_done(50);
        dp_en = 1'b1;
        @(negedge clk);

        // abort coincident with done_row_processing at layer 5 of iteration 2
        launch();
        push_exp(launch_cyc + 68, 0, 0, 1, 22, 21);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ifc.start_row_processing && ifc.current_layer == LW'(5) &&
                     ifc.iterations_used == IW'(1)) && n < 200);
        check("abort_point_found", int'(ifc.start_row_processing), 1);
        @(posedge clk);
        #1;
        ifc.abort = 1'b1;
        wait_done(5);
        ifc.abort = 1'b0;
        @(negedge clk);

        // asynchronous reset mid-iteration, then a clean full decode
        launch();
        repeat (100) @(negedge clk);
        check("busy_before_reset", int'(ifc.busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("outputs_in_reset", int'(all_outs), 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        launch();
        push_exp(launch_cyc + 492, 0, 0, 10, 160, 160);
        wait_done(600);
        @(negedge clk);

        // start held high: back-to-back decodes separated by one IDLE cycle
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        launch_cyc = cyc;
        push_exp(launch_cyc + 492, 0, 0, 10, 160, 160);
        push_exp(launch_cyc + 985, 0, 0, 10, 160, 160);
        wait_done(600);
        wait_done(600);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_after_held_start", int'(ifc.busy), 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
